// File: rtl/pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : pc_sequencer                                                     |
// | Brief   : simpleRISC control FSM: fetch, decode, execute handshake, PC update |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int               PCW      = 9,
  parameter int               IW       = 16,
  parameter logic [PCW-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PCW-1:0]  imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic            exec_start,
  output logic [IW-1:0]   exec_instr,
  input  logic            exec_done,
  input  logic [2:0]      flags_in,
  output logic [PCW-1:0]  pc,
  output logic [2:0]      flags_q,
  output logic            branch_taken,
  output logic            halted,
  output logic            busy
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_update = 3'd4;
  localparam logic [2:0] c_st_halt   = 3'd5;

  localparam logic [PCW-1:0] c_pc_one = PCW'(1);

  logic [2:0]     r_state;
  logic [2:0]     w_state_nxt;
  logic [PCW-1:0] r_pc;
  logic [IW-1:0]  r_ir;
  logic [2:0]     r_flags;
  logic           r_exec_start;

  logic           w_is_halt;
  logic           w_is_branch;
  logic           w_cond_true;
  logic           w_taken;
  logic [PCW-1:0] w_offset;
  logic [PCW-1:0] w_pc_nxt;

  assign w_is_halt   = (r_ir[15:14] == 2'b00) && (r_ir[13:11] == 3'b011);
  assign w_is_branch = (r_ir[15:14] == 2'b00) && (r_ir[13:11] == 3'b001);

  // Flags are {O,N,Z}; odd conditions test a flag set, even ones test it clear.
  always_comb begin
    w_cond_true = 1'b0;
    case (r_ir[10:8])
      3'b000:  w_cond_true = 1'b1;
      3'b001:  w_cond_true = r_flags[0];
      3'b010:  w_cond_true = ~r_flags[0];
      3'b011:  w_cond_true = r_flags[1];
      3'b100:  w_cond_true = ~r_flags[1];
      3'b101:  w_cond_true = r_flags[2];
      3'b110:  w_cond_true = ~r_flags[2];
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_taken  = w_is_branch && w_cond_true;
  assign w_offset = PCW'(signed'(r_ir[7:0]));
  assign w_pc_nxt = w_taken ? (r_pc + w_offset) : (r_pc + c_pc_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (run) w_state_nxt = c_st_fetch;
      c_st_fetch:  if (imem_ack) w_state_nxt = c_st_decode;
      c_st_decode: begin
        if (w_is_halt)        w_state_nxt = c_st_halt;
        else if (w_is_branch) w_state_nxt = c_st_update;
        else                  w_state_nxt = c_st_exec;
      end
      c_st_exec:   if (exec_done) w_state_nxt = c_st_update;
      c_st_update: w_state_nxt = run ? c_st_fetch : c_st_idle;
      c_st_halt:   w_state_nxt = c_st_halt;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // exec_start is registered so it is high exactly on the first EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_flags      <= '0;
      r_exec_start <= 1'b0;
    end else begin
      r_exec_start <= (r_state == c_st_decode) && !w_is_halt && !w_is_branch;
      if ((r_state == c_st_fetch) && imem_ack) r_ir <= imem_rdata;
      if ((r_state == c_st_exec) && exec_done) r_flags <= flags_in;
      if (r_state == c_st_update) r_pc <= w_pc_nxt;
    end
  end

  always_comb begin
    imem_req     = (r_state == c_st_fetch);
    imem_addr    = r_pc;
    exec_start   = r_exec_start;
    exec_instr   = r_ir;
    pc           = r_pc;
    flags_q      = r_flags;
    branch_taken = (r_state == c_st_update) && w_taken;
    halted       = (r_state == c_st_halt);
    busy         = (r_state != c_st_idle) && (r_state != c_st_halt);
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_pc_sequencer                                                  |
// | Brief   : directed self-checking bench with imem and datapath responders   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int PCW = 9;
  localparam int IW  = 16;

  localparam logic [15:0] c_halt = 16'h1800;
  localparam logic [15:0] c_alu  = 16'h4000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ack;
  logic [IW-1:0]  imem_rdata;
  logic           exec_start;
  logic [IW-1:0]  exec_instr;
  logic           exec_done;
  logic [2:0]     flags_in;
  logic [PCW-1:0] pc;
  logic [2:0]     flags_q;
  logic           branch_taken;
  logic           halted;
  logic           busy;

  logic [IW-1:0]  mem [0:511];
  int             imem_wait = 0;
  int             exec_wait = 0;
  logic [2:0]     exec_flags = 3'b000;
  int             exec_cnt = 0;
  int             br_cnt = 0;
  int             req_drop = 0;
  int             addr_chg = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             cyc;

  always #5 clk = ~clk;

  pc_sequencer #(.PCW(PCW), .IW(IW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .exec_start(exec_start), .exec_instr(exec_instr), .exec_done(exec_done), .flags_in(flags_in),
    .pc(pc), .flags_q(flags_q), .branch_taken(branch_taken), .halted(halted), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] br(input logic [2:0] cond, input logic [7:0] im8);
    return {2'b00, 3'b001, cond, im8};
  endfunction

  // Instruction memory: ack after imem_wait idle cycles of held request.
  initial begin : imem_resp
    int cnt;
    logic prev_req, prev_ack;
    logic [PCW-1:0] prev_addr;
    cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; imem_ack = 1'b0;
      end else begin
        if (prev_req && !prev_ack) begin
          if (!imem_req) req_drop++;
          else if (imem_addr != prev_addr) addr_chg++;
        end
        if (imem_req) begin
          if (cnt >= imem_wait) begin
            imem_ack = 1'b1; imem_rdata = mem[imem_addr]; cnt = 0;
          end else begin
            imem_ack = 1'b0; imem_rdata = 16'hDEAD; cnt++;
          end
        end else begin
          imem_ack = 1'b0; cnt = 0;
        end
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      end
    end
  end

  // Datapath: done after exec_wait cycles; flags_in carries junk when not done.
  initial begin : exec_resp
    int cnt;
    bit pend;
    cnt = 0; pend = 1'b0;
    exec_done = 1'b0; flags_in = 3'b000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; exec_done = 1'b0;
      end else begin
        if (exec_start) begin exec_cnt++; pend = 1'b1; cnt = 0; end
        if (branch_taken) br_cnt++;
        if (pend && cnt >= exec_wait) begin
          exec_done = 1'b1; flags_in = exec_flags; pend = 1'b0;
        end else begin
          exec_done = 1'b0; flags_in = ~exec_flags;
          if (pend) cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    run = 1'b0;
    exec_cnt = 0; br_cnt = 0; req_drop = 0; addr_chg = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load_halts();
    for (int i = 0; i < 512; i++) mem[i] = c_halt;
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
  endtask

  task automatic wait_halt(input string tag, output int n);
    n = 0;
    while (!halted && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_halt_reached"}, halted, 1);
  endtask

  task automatic wait_exec_start(input string tag);
    int n = 0;
    while (!exec_start && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_exec_start_seen"}, exec_start, 1);
  endtask

  initial begin
    load_halts();

    // 1: reset state, then reset in the middle of an EXEC at pc=5
    do_reset();
    @(posedge clk); #1;
    check_eq("rst_pc", pc, 0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_start", exec_start, 0);
    check_eq("rst_br", branch_taken, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", flags_q, 0);
    check_eq("rst_ir", exec_instr, 0);
    repeat (3) @(posedge clk); #1;
    check_eq("idle_no_run", busy, 0);
    mem[0] = br(3'b000, 8'd5); mem[5] = c_alu; exec_wait = 20;
    start_run();
    wait_exec_start("midrst");
    check_eq("midrst_pc_before", pc, 5);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_pc", pc, 0);
    check_eq("midrst_start", exec_start, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ir", exec_instr, 0);

    // 2: {ALU, HALT} with 0-wait then 3-wait fetches
    load_halts(); mem[0] = c_alu; mem[1] = c_halt;
    exec_wait = 0; exec_flags = 3'b000;
    for (int w = 0; w <= 3; w += 3) begin
      imem_wait = w;
      do_reset();
      start_run();
      wait_halt("seq", cyc);
      check_eq("seq_latency", cyc, 7 + 2 * w);
      check_eq("seq_pc", pc, 1);
      check_eq("seq_exec_cnt", exec_cnt, 1);
      check_eq("seq_busy", busy, 0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); run = ~run;
      repeat (2) @(posedge clk); #1;
      check_eq("halt_sticky", halted, 1);
      check_eq("halt_pc", pc, 1);
      check_eq("halt_req", imem_req, 0);
    end

    // 3: unconditional branch +3
    imem_wait = 0;
    load_halts(); mem[0] = br(3'b000, 8'd3);
    do_reset(); start_run();
    wait_halt("br", cyc);
    check_eq("br_latency", cyc, 6);
    check_eq("br_pc", pc, 3);
    check_eq("br_taken_cnt", br_cnt, 1);
    check_eq("br_exec_cnt", exec_cnt, 0);

    // 4a: Z set, cond=Z at pc=3
    load_halts(); mem[0] = c_alu; mem[1] = c_alu; mem[2] = c_alu; mem[3] = br(3'b001, 8'd3);
    exec_flags = 3'b001;
    do_reset(); start_run();
    wait_halt("z", cyc);
    check_eq("z_pc", pc, 6);
    check_eq("z_flags", flags_q, 3'b001);
    check_eq("z_exec_cnt", exec_cnt, 3);
    check_eq("z_br_cnt", br_cnt, 1);

    // 4b: Z clear, cond=!Z
    load_halts(); mem[0] = c_alu; mem[1] = br(3'b010, 8'd3);
    exec_flags = 3'b000;
    do_reset(); start_run();
    wait_halt("nz", cyc);
    check_eq("nz_pc", pc, 4);
    check_eq("nz_br_cnt", br_cnt, 1);

    // 4c: never
    load_halts(); mem[0] = c_alu; mem[1] = br(3'b111, 8'd3);
    do_reset(); start_run();
    wait_halt("never", cyc);
    check_eq("never_pc", pc, 2);
    check_eq("never_br_cnt", br_cnt, 0);

    // 4d: O,N set: !N not taken, then O taken; flags_q untouched by branches
    load_halts(); mem[0] = c_alu; mem[1] = br(3'b100, 8'd3); mem[2] = br(3'b101, 8'd3);
    exec_flags = 3'b110;
    do_reset(); start_run();
    wait_halt("on", cyc);
    check_eq("on_pc", pc, 5);
    check_eq("on_br_cnt", br_cnt, 1);
    check_eq("on_flags", flags_q, 3'b110);

    // 5a: branch -1 to 511, ALU at 511 wraps to 0
    load_halts(); mem[0] = br(3'b000, 8'hFF); mem[511] = c_alu;
    exec_flags = 3'b000;
    do_reset(); start_run();
    cyc = 0;
    while (br_cnt == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check_eq("wrap_branch_seen", br_cnt, 1);
    mem[0] = c_halt;
    wait_halt("wrap", cyc);
    check_eq("wrap_pc", pc, 0);
    check_eq("wrap_exec_cnt", exec_cnt, 1);

    // 5b: branch -4 at pc=2 -> 510
    load_halts(); mem[0] = c_alu; mem[1] = c_alu; mem[2] = br(3'b000, 8'hFC);
    do_reset(); start_run();
    wait_halt("neg", cyc);
    check_eq("neg_pc", pc, 510);

    // 6a: 5-wait fetches, request and address must hold until ack
    load_halts(); mem[0] = c_alu;
    imem_wait = 5; exec_wait = 0;
    do_reset(); start_run();
    wait_halt("slow", cyc);
    check_eq("slow_latency", cyc, 17);
    check_eq("slow_req_drop", req_drop, 0);
    check_eq("slow_addr_chg", addr_chg, 0);
    check_eq("slow_pc", pc, 1);

    // 6b: delayed exec_done
    imem_wait = 0; exec_wait = 2;
    do_reset(); start_run();
    wait_halt("edly", cyc);
    check_eq("edly_latency", cyc, 9);
    check_eq("edly_exec_cnt", exec_cnt, 1);

    // 6c: run dropped during EXEC
    load_halts(); mem[0] = c_alu; mem[1] = c_alu;
    exec_wait = 4;
    do_reset(); start_run();
    wait_exec_start("rdrop");
    run = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check_eq("rdrop_idle", busy, 0);
    check_eq("rdrop_pc", pc, 1);
    check_eq("rdrop_halted", halted, 0);
    repeat (5) @(posedge clk); #1;
    check_eq("rdrop_pc_hold", pc, 1);
    check_eq("rdrop_req", imem_req, 0);
    check_eq("rdrop_exec_cnt", exec_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
